// File: rtl/uart_pkg.sv
// UART shared definitions: state encoding, parameter limits, frame-length helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int MIN_CLKS_PER_BIT = 2;
    localparam int MIN_DATA_BITS    = 5;
    localparam int MAX_DATA_BITS    = 9;
    localparam int MIN_STOP_BITS    = 1;
    localparam int MAX_STOP_BITS    = 2;

    // Clock cycles one frame occupies the line (tx_busy high time).
    // The minimum start-to-start period is this plus one idle cycle.
    function automatic int frame_clks(input int clks_per_bit, input int data_bits,
                                      input int parity_en, input int stop_bits);
        return (1 + data_bits + parity_en + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Per-bit baud counter: counts 0..CLKS_PER_BIT-1 while enabled, tick on the last count.
// Latency: tick is combinational from the count; count wraps to 0 on the tick edge.
// Backpressure: none; clr has priority over en and forces the count to 0.
// Ports: clk, reset (async, active high), clr (sync clear), en (count enable),
//        tick (high in the final cycle of each bit period).
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_BITS LSB first, optional parity, 1-2 stop bits.
// Latency: tx falls one cycle after an accepted start; frame lasts frame_clks() cycles.
// Backpressure: start is only sampled in IDLE; requests while tx_busy are dropped.
// Ports: clk, reset (async, active high), start, data[DATA_BITS-1:0] in;
//        tx_busy, tx_done (one-cycle pulse), tx (registered serial line, idle high) out.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx
);

    localparam int IDX_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int IDX_W   = $clog2(IDX_MAX) + 1;
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    generate
        if (CLKS_PER_BIT < MIN_CLKS_PER_BIT ||
            DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS ||
            STOP_BITS < MIN_STOP_BITS || STOP_BITS > MAX_STOP_BITS) begin : g_bad_params
            $error("uart_tx_cfg: illegal CLKS_PER_BIT, DATA_BITS or STOP_BITS");
        end
    endgenerate

    uart_state_t          state, state_nx;
    logic [DATA_BITS-1:0] shreg, shreg_nx;
    logic [IDX_W-1:0]     bit_idx, bit_idx_nx;
    logic                 par_bit, par_bit_nx;
    logic                 tx_nx, done_nx;
    logic                 baud_clr, baud_en, tick;

    // Counter only runs inside a frame; acceptance clears it so the start
    // bit gets a full period regardless of where the last frame left it.
    assign baud_en = (state != IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .clr   (baud_clr),
        .en    (baud_en),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_nx;
            shreg   <= shreg_nx;
            bit_idx <= bit_idx_nx;
            par_bit <= par_bit_nx;
            tx      <= tx_nx;
            tx_busy <= (state_nx != IDLE);
            tx_done <= done_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        bit_idx_nx = bit_idx;
        par_bit_nx = par_bit;
        baud_clr   = 1'b0;
        done_nx    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nx   = START;
                    shreg_nx   = data;
                    bit_idx_nx = '0;
                    // Parity is fixed at capture so the shifting register
                    // never needs to be re-read.
                    par_bit_nx = (^data) ^ 1'(PARITY_ODD);
                    baud_clr   = 1'b1;
                end
            end
            START: begin
                if (tick) state_nx = DATA;
            end
            DATA: begin
                if (tick) begin
                    shreg_nx = shreg >> 1;
                    if (bit_idx == LAST_DATA) begin
                        bit_idx_nx = '0;
                        state_nx   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_idx_nx = bit_idx + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) state_nx = STOP;
            end
            STOP: begin
                if (tick) begin
                    if (bit_idx == LAST_STOP) begin
                        bit_idx_nx = '0;
                        state_nx   = IDLE;
                        done_nx    = 1'b1;
                    end else begin
                        bit_idx_nx = bit_idx + IDX_W'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // tx is registered from the next-state view so the line changes on
        // the same edge as the state, with no combinational path to the pin.
        case (state_nx)
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = shreg_nx[0];
            PARITY:  tx_nx = par_bit_nx;
            default: tx_nx = 1'b1;
        endcase
    end

endmodule
